// File: rtl/fma16_retire.sv
// fma16_retire: FIFO retire stage with qNaN canonicalisation, sticky fflags and a saturating retire counter
module fma16_retire #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_result,
    input  logic             in_nx,
    input  logic             in_of,
    input  logic             in_uf,
    input  logic             in_nv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       fflags,
    input  logic             fflags_clr,
    output logic [CNT_W-1:0] retired_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          push, pop;
    always_comb begin
        in_ready   = cnt != CW'(DEPTH);
        out_valid  = cnt != '0;
        push       = in_valid & in_ready;
        pop        = out_valid & out_ready;
        out_result = out_valid ? mem[rd_ptr][19:4] : 16'h0;
        out_flags  = out_valid ? mem[rd_ptr][3:0] : 4'h0;
    end
    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= {in_nv ? 16'h7E00 : in_result, in_nv, in_of, in_uf, in_nx};
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            fflags      <= '0;
            retired_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
            if (pop) fflags <= (fflags_clr ? 4'h0 : fflags) | out_flags;
            else if (fflags_clr) fflags <= 4'h0;
            if (pop && !(&retired_cnt)) retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fma16_retire.sv
// tb_fma16_retire: directed checks of the fma16 retire stage with hand-computed expectations
module tb_fma16_retire;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [15:0] in_result = 0;
    logic        in_nx = 0, in_of = 0, in_uf = 0, in_nv = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [15:0] out_result;
    logic [3:0]  out_flags;
    logic [3:0]  fflags;
    logic        fflags_clr = 0;
    logic [2:0]  retired_cnt;
    int checks = 0;
    int errors = 0;
    fma16_retire #(.DEPTH(2), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_nx(in_nx), .in_of(in_of), .in_uf(in_uf), .in_nv(in_nv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .fflags(fflags), .fflags_clr(fflags_clr), .retired_cnt(retired_cnt)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic set_in(input logic v, input logic [15:0] r, input logic [3:0] f);
        in_valid = v;
        in_result = r;
        {in_nv, in_of, in_uf, in_nx} = f;
    endtask
    initial begin
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_result", 32'(out_result), 0);
        check("rst_out_flags", 32'(out_flags), 0);
        check("rst_fflags", 32'(fflags), 0);
        check("rst_cnt", 32'(retired_cnt), 0);
        step();
        reset_n = 1;
        // test 1: single op, one cycle latency
        out_ready = 1;
        set_in(1, 16'h3C00, 4'b0000);
        step();
        set_in(0, 16'h0, 4'b0000);
        check("t1_out_valid", 32'(out_valid), 1);
        check("t1_out_result", 32'(out_result), 32'h3C00);
        check("t1_cnt_pre", 32'(retired_cnt), 0);
        step();
        check("t1_cnt", 32'(retired_cnt), 1);
        check("t1_empty", 32'(out_valid), 0);
        check("t1_fflags", 32'(fflags), 0);
        // test 2: backpressure, full, order
        out_ready = 0;
        set_in(1, 16'h4000, 4'b0000);
        step();
        check("t2_ready1", 32'(in_ready), 1);
        check("t2_head1", 32'(out_result), 32'h4000);
        set_in(1, 16'h4200, 4'b0000);
        step();
        check("t2_full", 32'(in_ready), 0);
        set_in(1, 16'h4400, 4'b0000);
        step();
        check("t2_held_ready", 32'(in_ready), 0);
        check("t2_held_head", 32'(out_result), 32'h4000);
        check("t2_held_cnt", 32'(retired_cnt), 1);
        out_ready = 1;
        step();
        check("t2_head2", 32'(out_result), 32'h4200);
        check("t2_ready2", 32'(in_ready), 1);
        step();
        check("t2_head3", 32'(out_result), 32'h4400);
        check("t2_cnt3", 32'(retired_cnt), 3);
        set_in(0, 16'h0, 4'b0000);
        step();
        check("t2_drained", 32'(out_valid), 0);
        check("t2_cnt4", 32'(retired_cnt), 4);
        // test 3: invalid canonicalised to qNaN
        out_ready = 0;
        set_in(1, 16'h7C01, 4'b1000);
        step();
        set_in(0, 16'h0, 4'b0000);
        check("t3_qnan", 32'(out_result), 32'h7E00);
        check("t3_flags", 32'(out_flags), 32'h8);
        check("t3_fflags_pending", 32'(fflags), 0);
        out_ready = 1;
        step();
        check("t3_fflags", 32'(fflags), 32'h8);
        fflags_clr = 1;
        step();
        fflags_clr = 0;
        check("t3_clr", 32'(fflags), 0);
        // test 4: sticky accumulation and clear-with-pop
        set_in(1, 16'h3C00, 4'b0001);
        step();
        set_in(1, 16'h3C00, 4'b0100);
        step();
        set_in(0, 16'h0, 4'b0000);
        step();
        check("t4_sticky", 32'(fflags), 32'h5);
        out_ready = 0;
        set_in(1, 16'h3C00, 4'b0010);
        step();
        set_in(0, 16'h0, 4'b0000);
        check("t4_pending", 32'(fflags), 32'h5);
        out_ready = 1;
        fflags_clr = 1;
        step();
        fflags_clr = 0;
        check("t4_clr_pop", 32'(fflags), 32'h2);
        check("t4_cnt_sat", 32'(retired_cnt), 7);
        // test 6: async reset with FIFO full
        out_ready = 0;
        set_in(1, 16'h4000, 4'b0001);
        step();
        step();
        set_in(0, 16'h0, 4'b0000);
        check("t6_full", 32'(in_ready), 0);
        #2 reset_n = 0;
        #1;
        check("t6_out_valid", 32'(out_valid), 0);
        check("t6_in_ready", 32'(in_ready), 1);
        check("t6_fflags", 32'(fflags), 0);
        check("t6_cnt", 32'(retired_cnt), 0);
        step();
        reset_n = 1;
        step();
        check("t6_no_stale", 32'(out_valid), 0);
        check("t6_result", 32'(out_result), 0);
        // test 5: counter saturation
        out_ready = 1;
        set_in(1, 16'h3C00, 4'b0000);
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("t5_cnt%0d", i), 32'(retired_cnt), (i - 1 > 7) ? 7 : i - 1);
        end
        set_in(0, 16'h0, 4'b0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
